axi_data_rd_loader: RTL and testbench

AXI4 read-master loader that fetches a contiguous block of packed 64-bit-per-coefficient data from host memory and unpacks it into the accelerator's input buffer. It is the inbound counterpart of the output write path. It issues incrementing read bursts, extracts the low DATA_WIDTH bits of every 64-bit lane, and packs four coefficients per buffer write. It sits between the kernel's AXI read port and the input-buffer RAM write port, and is started and monitored by the top-level control FSM.

---
 rtl/axi_data_rd_loader.sv | 209 ++++++++++++++++++++
 tb/tb_axi_data_rd_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_data_rd_loader.sv
// AXI4 read master that streams a contiguous host block into the input buffer,
// truncating each 64-bit lane to DATA_WIDTH and packing four coefficients per write.
module axi_data_rd_loader #(
    parameter int AXI_ADDR_WIDTH      = 64,
    parameter int AXI_DATA_WIDTH      = 128,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int DATA_WIDTH          = 39,
    parameter int MAX_BURST_LEN       = 16,
    parameter int MAX_OUTSTANDING     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    output logic [AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic [7:0]                      m_axi_arlen,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready,
    input  logic [AXI_DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rlast,
    input  logic                            i_axird_start,
    output logic                            o_axird_done,
    output logic                            o_axird_err,
    input  logic [AXI_ADDR_WIDTH-1:0]       data_ptr,
    input  logic [AXI_XFER_SIZE_WIDTH-1:0]  data_size_bytes,
    output logic                            o_axird_wren,
    output logic [11:0]                     o_axird_wraddr,
    output logic [4*DATA_WIDTH-1:0]         o_axird_wrdata
);
    localparam int AW = AXI_ADDR_WIDTH;
    localparam int SW = AXI_XFER_SIZE_WIDTH;
    localparam int CW = SW - 3;
    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int BW = $clog2(MAX_BURST_LEN) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DRAIN} state_e;

    state_e            state_q, state_d;
    logic              arvalid_q, arvalid_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [AW-1:0]     next_addr_q, next_addr_d;
    logic [CW-1:0]     issue_left_q, issue_left_d;
    logic [CW-1:0]     rx_left_q, rx_left_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              odd_q, odd_d;
    logic [PW-1:0]     lo_q, lo_d;
    logic              wren_q, wren_d;
    logic [11:0]       wraddr_q, wraddr_d;
    logic [11:0]       wptr_q, wptr_d;
    logic [4*DW-1:0]   wrdata_q, wrdata_d;
    logic              err_q, err_d;

    logic              ar_hs;
    logic              r_hs;
    logic [OW-1:0]     out_nxt;
    logic [BW-1:0]     burst;
    logic [SW:0]       sz_rnd;
    logic [CW-1:0]     tot;
    logic [AW-1:0]     base;
    logic [DW-1:0]     lane0;
    logic [DW-1:0]     lane1;
    logic              unused_bits;

    function automatic logic [BW-1:0] blen(input logic [CW-1:0] n);
        if (n >= CW'(MAX_BURST_LEN)) return BW'(MAX_BURST_LEN);
        return n[BW-1:0];
    endfunction

    assign ar_hs   = arvalid_q && m_axi_arready;
    assign r_hs    = (state_q == S_XFER) && m_axi_rvalid;
    assign out_nxt = outst_q + OW'(ar_hs) - OW'(r_hs && m_axi_rlast);
    assign sz_rnd  = {1'b0, data_size_bytes} + (SW+1)'(15);
    assign tot     = sz_rnd[SW:4];
    assign base    = {data_ptr[AW-1:4], 4'b0000};
    assign lane0   = m_axi_rdata[DW-1:0];
    assign lane1   = m_axi_rdata[64 +: DW];

    assign unused_bits = ^{m_axi_rdata[63:DW], m_axi_rdata[AXI_DATA_WIDTH-1:64+DW],
                           data_ptr[3:0], sz_rnd[3:0]};

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        next_addr_d  = next_addr_q;
        issue_left_d = issue_left_q;
        rx_left_d    = rx_left_q;
        outst_d      = outst_q;
        odd_d        = odd_q;
        lo_d         = lo_q;
        wren_d       = 1'b0;
        wraddr_d     = wraddr_q;
        wptr_d       = wptr_q;
        wrdata_d     = wrdata_q;
        err_d        = err_q;
        burst        = '0;
        unique case (state_q)
            S_IDLE: begin
                if (i_axird_start) begin
                    // first AR is presented straight from the start edge
                    burst        = blen(tot);
                    state_d      = S_XFER;
                    arvalid_d    = (tot != '0);
                    araddr_d     = base;
                    arlen_d      = (tot != '0) ? 8'(burst) - 8'd1 : 8'd0;
                    next_addr_d  = base + AW'({burst, 4'b0000});
                    issue_left_d = tot - CW'(burst);
                    rx_left_d    = tot;
                    outst_d      = '0;
                    odd_d        = 1'b0;
                    wptr_d       = '0;
                    err_d        = 1'b0;
                end
            end
            S_XFER: begin
                outst_d = out_nxt;
                if (ar_hs) arvalid_d = 1'b0;
                if ((!arvalid_q || m_axi_arready) && issue_left_q != '0 &&
                    out_nxt < OW'(MAX_OUTSTANDING)) begin
                    burst        = blen(issue_left_q);
                    arvalid_d    = 1'b1;
                    araddr_d     = next_addr_q;
                    arlen_d      = 8'(burst) - 8'd1;
                    next_addr_d  = next_addr_q + AW'({burst, 4'b0000});
                    issue_left_d = issue_left_q - CW'(burst);
                end
                if (r_hs) begin
                    rx_left_d = rx_left_q - 1'b1;
                    odd_d     = !odd_q;
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    if (odd_q) begin
                        wren_d   = 1'b1;
                        wrdata_d = {lane1, lane0, lo_q};
                        wraddr_d = wptr_q;
                        wptr_d   = wptr_q + 12'd1;
                    end else begin
                        lo_d = {lane1, lane0};
                    end
                end
                if (rx_left_q == '0 || (r_hs && rx_left_q == CW'(1)))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (odd_q) begin
                    wren_d   = 1'b1;
                    wrdata_d = {{PW{1'b0}}, lo_q};
                    wraddr_d = wptr_q;
                    wptr_d   = wptr_q + 12'd1;
                    odd_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            next_addr_q  <= '0;
            issue_left_q <= '0;
            rx_left_q    <= '0;
            outst_q      <= '0;
            odd_q        <= 1'b0;
            lo_q         <= '0;
            wren_q       <= 1'b0;
            wraddr_q     <= '0;
            wptr_q       <= '0;
            wrdata_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            next_addr_q  <= next_addr_d;
            issue_left_q <= issue_left_d;
            rx_left_q    <= rx_left_d;
            outst_q      <= outst_d;
            odd_q        <= odd_d;
            lo_q         <= lo_d;
            wren_q       <= wren_d;
            wraddr_q     <= wraddr_d;
            wptr_q       <= wptr_d;
            wrdata_q     <= wrdata_d;
            err_q        <= err_d;
        end
    end

    assign m_axi_arvalid  = arvalid_q;
    assign m_axi_araddr   = araddr_q;
    assign m_axi_arlen    = arlen_q;
    assign m_axi_rready   = (state_q == S_XFER);
    assign o_axird_done   = (state_q == S_IDLE);
    assign o_axird_err    = err_q;
    assign o_axird_wren   = wren_q;
    assign o_axird_wraddr = wraddr_q;
    assign o_axird_wrdata = wrdata_q;

endmodule

// File: tb/tb_axi_data_rd_loader.sv
// Bench for axi_data_rd_loader: AXI read slave model plus
// scoreboards of expected AR requests and buffer writes.
module tb_axi_data_rd_loader;
    localparam int AW = 64;
    localparam int DW = 39;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
    } ar_t;
    typedef struct {
        logic [11:0]     a;
        logic [4*DW-1:0] d;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            m_axi_arvalid;
    logic            m_axi_arready = 1'b0;
    logic [AW-1:0]   m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic            m_axi_rvalid = 1'b0;
    logic            m_axi_rready;
    logic [127:0]    m_axi_rdata = '0;
    logic [1:0]      m_axi_rresp = '0;
    logic            m_axi_rlast = 1'b0;
    logic            i_axird_start = 1'b0;
    logic            o_axird_done;
    logic            o_axird_err;
    logic [AW-1:0]   data_ptr = '0;
    logic [31:0]     data_size_bytes = '0;
    logic            o_axird_wren;
    logic [11:0]     o_axird_wraddr;
    logic [4*DW-1:0] o_axird_wrdata;

    axi_data_rd_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .m_axi_arvalid   (m_axi_arvalid),
        .m_axi_arready   (m_axi_arready),
        .m_axi_araddr    (m_axi_araddr),
        .m_axi_arlen     (m_axi_arlen),
        .m_axi_rvalid    (m_axi_rvalid),
        .m_axi_rready    (m_axi_rready),
        .m_axi_rdata     (m_axi_rdata),
        .m_axi_rresp     (m_axi_rresp),
        .m_axi_rlast     (m_axi_rlast),
        .i_axird_start   (i_axird_start),
        .o_axird_done    (o_axird_done),
        .o_axird_err     (o_axird_err),
        .data_ptr        (data_ptr),
        .data_size_bytes (data_size_bytes),
        .o_axird_wren    (o_axird_wren),
        .o_axird_wraddr  (o_axird_wraddr),
        .o_axird_wrdata  (o_axird_wrdata)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nbad = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int nwr = 0;
    int rx_cnt = 0;
    int err_beat = -1;
    int ar_pct = 100;
    int rv_pct = 100;
    int out_cnt = 0;
    logic            ovr_en = 1'b0;
    logic [63:0]     ovr_addr = '0;
    logic [127:0]    ovr_data = '0;
    logic [4*DW-1:0] last_wr = '0;

    ar_t exp_ar[$];
    ar_t burst_q[$];
    wr_t exp_wr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        ncmp++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input logic [63:0] a);
        logic [31:0] x;
        x = a[31:0] ^ 32'h5bd1_e995;
        if (ovr_en && a == ovr_addr) return ovr_data;
        return {x * 32'h9e37_79b1, ~x, x * 32'h85eb_ca6b, x + 32'h0123_4567};
    endfunction

    function automatic logic [2*DW-1:0] pack2(input logic [127:0] d);
        logic [63:0] l0;
        logic [63:0] l1;
        l0 = d[63:0];
        l1 = d[127:64];
        return {l1[DW-1:0], l0[DW-1:0]};
    endfunction

    task automatic push_expected(input logic [63:0] ptr, input logic [31:0] size);
        logic [63:0]   base;
        logic [63:0]   a;
        longint        nb;
        longint        rem;
        longint        b;
        logic [2*DW-1:0] lo;
        logic [2*DW-1:0] hi;
        base = {ptr[63:4], 4'b0000};
        nb   = (longint'(size) + 15) / 16;
        rem  = nb;
        a    = base;
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            exp_ar.push_back('{a, 8'(b - 1)});
            a   = a + 64'(b * 16);
            rem = rem - b;
        end
        for (longint k = 0; 2 * k < nb; k++) begin
            lo = pack2(beat_data(base + 64'(32 * k)));
            hi = (2 * k + 1 < nb) ? pack2(beat_data(base + 64'(32 * k + 16))) : '0;
            exp_wr.push_back('{12'(k), {hi, lo}});
        end
    endtask

    // AXI slave + write monitor, all decisions taken on the falling edge
    initial begin : slave
        logic        r_pend;
        logic        ar_wait;
        logic [63:0] hold_addr;
        logic [7:0]  hold_len;
        int          rb;
        ar_t         e;
        wr_t         w;
        r_pend  = 1'b0;
        ar_wait = 1'b0;
        hold_addr = '0;
        hold_len  = '0;
        rb = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                burst_q.delete();
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b0;
                m_axi_rlast   = 1'b0;
                r_pend  = 1'b0;
                ar_wait = 1'b0;
                rb      = 0;
                out_cnt = 0;
                continue;
            end
            if (o_axird_wren) begin
                nwr++;
                wr_cyc  = cyc;
                last_wr = o_axird_wrdata;
                if (exp_wr.size() == 0) begin
                    check("wr_extra", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    check("wraddr", o_axird_wraddr, w.a);
                    check("wrdata", o_axird_wrdata, w.d);
                end
            end
            if (r_pend) begin
                rx_cnt++;
                if (m_axi_rlast) begin
                    void'(burst_q.pop_front());
                    rb = 0;
                    out_cnt--;
                end else begin
                    rb++;
                end
                m_axi_rvalid = 1'b0;
            end
            if (!m_axi_rvalid && burst_q.size() > 0 &&
                $urandom_range(99) < rv_pct) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = beat_data(burst_q[0].addr + 64'(16 * rb));
                m_axi_rlast  = (rb == int'(burst_q[0].len));
                m_axi_rresp  = (rx_cnt == err_beat) ? 2'b10 : 2'b00;
            end
            r_pend = m_axi_rvalid && m_axi_rready;
            if (ar_wait) begin
                check("ar_hold_valid", m_axi_arvalid, 1);
                check("ar_hold_addr", m_axi_araddr, hold_addr);
                check("ar_hold_len", m_axi_arlen, hold_len);
            end
            m_axi_arready = ($urandom_range(99) < ar_pct);
            ar_wait   = m_axi_arvalid && !m_axi_arready;
            hold_addr = m_axi_araddr;
            hold_len  = m_axi_arlen;
            if (m_axi_arvalid && m_axi_arready) begin
                if (exp_ar.size() == 0) begin
                    check("ar_extra", 1, 0);
                end else begin
                    e = exp_ar.pop_front();
                    check("araddr", m_axi_araddr, e.addr);
                    check("arlen", m_axi_arlen, e.len);
                end
                burst_q.push_back('{m_axi_araddr, m_axi_arlen});
                out_cnt++;
                check("outstanding_le4", out_cnt <= 4, 1);
            end
        end
    end

    task automatic start_xfer(input logic [63:0] ptr, input logic [31:0] size,
                              input bit restart);
        push_expected(ptr, size);
        rx_cnt = 0;
        nwr    = 0;
        @(negedge clk);
        data_ptr        = ptr;
        data_size_bytes = size;
        i_axird_start   = 1'b1;
        @(negedge clk);
        i_axird_start = 1'b0;
        check("done_low_at_start", o_axird_done, 0);
        check("arvalid_at_start", m_axi_arvalid, size != 0);
        check("err_clear_at_start", o_axird_err, 0);
        if (restart) begin
            // a second start while busy must not disturb the transfer
            data_ptr        = 64'hdead_0000;
            data_size_bytes = 32'd16;
            i_axird_start   = 1'b1;
            @(negedge clk);
            i_axird_start = 1'b0;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!o_axird_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", o_axird_done, 1);
    endtask

    task automatic run_xfer(input logic [63:0] ptr, input logic [31:0] size,
                            input bit exp_err, input bit restart, output int n);
        longint nb;
        nb = (longint'(size) + 15) / 16;
        start_xfer(ptr, size, restart);
        wait_done(n);
        check("ar_left", exp_ar.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("wr_count", nwr, (nb + 1) / 2);
        check("err", o_axird_err, exp_err);
        if (nwr > 0) check("done_after_last_wr", cyc - wr_cyc, 1);
    endtask

    initial begin : main
        int n;
        #1;
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_arlen", m_axi_arlen, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_wren", o_axird_wren, 0);
        check("rst_wraddr", o_axird_wraddr, 0);
        check("rst_wrdata", o_axird_wrdata, 0);
        check("rst_err", o_axird_err, 0);
        check("rst_done", o_axird_done, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(64'h1000, 32'd512, 0, 0, n);
        run_xfer(64'h2003, 32'd48, 0, 0, n);
        run_xfer(64'h2100, 32'd40, 0, 0, n);

        ovr_en   = 1'b1;
        ovr_addr = 64'h3000;
        ovr_data = {64'h0000_0040_0000_0002, 64'hFFFF_FF80_0000_0001};
        run_xfer(64'h3000, 32'd32, 0, 0, n);
        check("lane_trunc", last_wr[2*DW-1:0], {39'h40_0000_0002, 39'h1});
        ovr_en = 1'b0;

        ar_pct = 50;
        rv_pct = 30;
        run_xfer(64'h10000, 32'd2048, 0, 1, n);
        ar_pct = 20;
        run_xfer(64'h20000, 32'd1000, 0, 0, n);
        ar_pct = 100;
        rv_pct = 100;

        err_beat = 5;
        run_xfer(64'h8000, 32'd160, 1, 0, n);
        repeat (3) @(negedge clk);
        check("err_sticky", o_axird_err, 1);
        err_beat = -1;
        run_xfer(64'h8000, 32'd160, 0, 0, n);

        run_xfer(64'h5000, 32'd0, 0, 0, n);
        check("zero_done_low_cycles", n, 2);

        run_xfer(64'h40000, 32'd131104, 0, 0, n);
        check("wrap_last_addr", o_axird_wraddr, 12'd0);

        start_xfer(64'h4000, 32'd256, 0);
        n = 0;
        while (rx_cnt < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beat5_reached", rx_cnt >= 5, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_done", o_axird_done, 1);
        check("mid_rst_rready", m_axi_rready, 0);
        check("mid_rst_arvalid", m_axi_arvalid, 0);
        check("mid_rst_wren", o_axird_wren, 0);
        exp_ar.delete();
        exp_wr.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_xfer(64'h4000, 32'd256, 0, 0, n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
